spi_cmd_decoder: RTL
====================

// Module: spi_cmd_decoder
// PURPOSE
//  Downstream of the SPI byte receiver. Consumes its val/rdy byte stream and decodes 1- or 2-byte commands against a local register bank.
//  Read data goes to the MISO transmit side through its own val/rdy port; register contents are exported to the core.
//  Frame abort follows chip-select.
// PARAMETERS
//  NREGS   8    number of 8-bit registers, 1..128
//  ADDR_W  3    register address width, = clog2(NREGS)
//  RST_VAL 8'h00 reset value of every register
// PORTS
//  clk       in   1           system clock; only clock in the block
//  rst       in   1           synchronous, active-high reset
//  cs        in   1           raw SPI chip-select, active low; 2-flop synchronised here
//  in_data   in   8           byte from receiver
//  in_val    in   1           in_data valid; held until accepted
//  in_rdy    out  1           decoder can accept a byte
//  rd_data   out  8           read response byte
//  rd_val    out  1           rd_data valid
//  rd_rdy    in   1           transmit side accepts rd_data
//  wr_stb    out  1           one-cycle pulse: register written
//  wr_addr   out  ADDR_W      address of the write flagged by wr_stb
//  regs_flat out  NREGS*8     register bank, reg i at [8i+7:8i]
//  err_cnt   out  8           saturating count of invalid-address commands
// BEHAVIOUR
//  Reset (synchronous, rst=1 at posedge):
//   - state=IDLE; in_rdy=1; rd_val=0; rd_data=0; wr_stb=0; wr_addr=0
//   - all regs=RST_VAL; err_cnt=0; cs sync flops=1
//  Accept: a byte is taken on a cycle with in_val & in_rdy. in_rdy = (state!=RESP), decoded from registered state only.
//  Header byte: bit7 W (1=write, 0=read); bits[6:0] address A. A>=NREGS is invalid.
//  FSM:
//   - IDLE: header accepted.
//     - W=1 -> DATA, latching A.
//     - W=0 -> RESP. Next cycle rd_val=1, rd_data = reg[A], or 8'hFF if A is invalid (read latency 1 cycle).
//   - DATA: data byte accepted -> IDLE.
//     - A valid: reg[A] updated; wr_stb=1 and wr_addr=A on the next cycle (registered).
//     - A invalid: byte discarded, no wr_stb.
//     - Synced cs high while in DATA and no byte accepted that cycle -> IDLE, nothing written. Synced cs means the 2nd flop, so there are 2 cycles of delay.
//   - RESP: rd_val held with rd_data stable until rd_val & rd_rdy; then rd_val=0 -> IDLE the same edge.
//     - RESP is not aborted by cs.
//     - in_val during RESP is stalled (in_rdy=0), never dropped.
//  err_cnt: +1 on the edge an invalid header is accepted (read or write); saturates at 8'hFF, no wrap.
//  Simultaneous events:
//   - rd_rdy handshake and pending in_val in RESP: response retires; the byte is accepted on a following cycle.
//   - In IDLE, cs high does not block acceptance; stray bytes outside a frame are decoded normally.
//   - rst mid-command: everything returns to reset values; a partial write is never committed.
//  Widths: address compare done on full 7-bit A against NREGS; only A[ADDR_W-1:0] is used for indexing.
// STRUCTURE
//  Shared header spi_defs.vh:
//   - state encodings (IDLE=2'd0, DATA=2'd1, RESP=2'd2)
//   - header bit position SPI_W_BIT=7
//   - invalid-read fill SPI_RD_FILL=8'hFF
//  One sub-module: spi_reg_bank (NREGS x 8, sync write port, combinational read, flat export).
//  FSM, cs sync and err_cnt stay in the top module.
// TESTING
//  1. Write: bytes 8'h83, 8'h5A with cs low -> 1 cycle after 2nd accept: wr_stb=1, wr_addr=3; regs_flat[31:24]=8'h5A.
//  2. Read: after test 1, byte 8'h03 -> next cycle rd_val=1, rd_data=8'h5A. Hold rd_rdy=0 10 cycles: data stable, in_rdy=0. Then rd_rdy=1 -> rd_val=0.
//  3. Invalid address: 8'h8A,8'h11 then 8'h0A (NREGS=8) -> no wr_stb; read returns 8'hFF; err_cnt=2.
//  4. Abort: 8'h81 accepted, then cs high for 3 cycles, then byte 8'h77 -> 8'h77 parsed as header (read of reg 0x77, invalid); reg1 unchanged.
//  5. Backpressure: in_val held with 8'h02 during RESP while rd_rdy toggles -> exactly one accept, after the response retires; no byte lost or duplicated.
//  6. Reset mid-DATA after header 8'h84: rst 1 cycle -> regs all RST_VAL, state IDLE, err_cnt=0. 300 invalid headers -> err_cnt=8'hFF.

Source files
------------

// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder.
//   state_t      : decoder FSM states (IDLE / DATA / RESP)
//   SPI_W_BIT    : position of the write flag inside a header byte
//   SPI_RD_FILL  : byte returned when a read targets a non-existent register
package spi_cmd_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int         SPI_W_BIT   = 7;
  localparam logic [7:0] SPI_RD_FILL = 8'hFF;

endpackage

// File: rtl/spi_reg_bank.sv
// Register bank: NREGS x 8-bit registers with one synchronous write port,
// one combinational read port and a flat export of every register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (all regs -> RST_VAL)
//   we         : write enable
//   waddr      : write address
//   wdata      : write data
//   raddr      : read address
//   rdata      : combinational read data
//   regs_flat  : reg i at [8i+7:8i]
module spi_reg_bank #(
  parameter int         NREGS   = 8,
  parameter int         ADDR_W  = 3,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [7:0]           wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [7:0]           rdata,
  output logic [NREGS*8-1:0]   regs_flat
);

  logic [7:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= RST_VAL;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Callers only use rdata when the address has been range-checked.
  assign rdata = mem[raddr];

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = mem[g];
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder. Takes bytes from the SPI receiver and decodes
// 1-byte reads / 2-byte writes against a local register bank.
// Header byte: bit7 = write flag, bits[6:0] = register address.
//
// Handshake rule (both byte ports): a transfer happens on a clock edge where
// val and rdy are both high; the producer holds val and data stable until
// that edge, and rdy never depends combinationally on val.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   cs         : raw chip-select (active low), synchronised internally
//   in_data/in_val/in_rdy : incoming byte stream
//   rd_data/rd_val/rd_rdy : read response towards the MISO side
//   wr_stb, wr_addr       : one-cycle pulse after a register write
//   regs_flat  : register bank export
//   err_cnt    : saturating count of invalid-address headers
module spi_cmd_decoder
  import spi_cmd_decoder_pkg::*;
#(
  parameter int         NREGS   = 8,
  parameter int         ADDR_W  = 3,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic [7:0]           in_data,
  input  logic                 in_val,
  output logic                 in_rdy,
  output logic [7:0]           rd_data,
  output logic                 rd_val,
  input  logic                 rd_rdy,
  output logic                 wr_stb,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [NREGS*8-1:0]   regs_flat,
  output logic [7:0]           err_cnt
);

  localparam logic [7:0] NREGS_B = 8'(NREGS);

  state_t              state, state_nxt;
  logic                cs_meta, cs_sync;
  logic [ADDR_W-1:0]   hdr_addr;
  logic                hdr_ok;
  logic                accept;
  logic [6:0]          cur_a;
  logic                cur_ok;
  logic [7:0]          bank_rdata;

  // Control strobes from the next-state logic.
  logic                do_write;
  logic                load_rd;
  logic                latch_hdr;
  logic                bump_err;

  assign in_rdy = (state != ST_RESP);
  assign rd_val = (state == ST_RESP);
  assign accept = in_val && in_rdy;

  // Range check uses the full 7-bit address; only low bits index the bank.
  assign cur_a  = in_data[6:0];
  assign cur_ok = ({1'b0, cur_a} < NREGS_B);

  spi_reg_bank #(
    .NREGS   (NREGS),
    .ADDR_W  (ADDR_W),
    .RST_VAL (RST_VAL)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we        (do_write),
    .waddr     (hdr_addr),
    .wdata     (in_data),
    .raddr     (cur_a[ADDR_W-1:0]),
    .rdata     (bank_rdata),
    .regs_flat (regs_flat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    load_rd   = 1'b0;
    latch_hdr = 1'b0;
    bump_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          bump_err = !cur_ok;
          if (in_data[SPI_W_BIT]) begin
            latch_hdr = 1'b1;
            state_nxt = ST_DATA;
          end else begin
            load_rd   = 1'b1;
            state_nxt = ST_RESP;
          end
        end
      end
      ST_DATA: begin
        // An arriving data byte wins over a same-cycle chip-select abort.
        if (accept) begin
          do_write  = hdr_ok;
          state_nxt = ST_IDLE;
        end else if (cs_sync) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (rd_rdy) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta  <= 1'b1;
      cs_sync  <= 1'b1;
      hdr_addr <= '0;
      hdr_ok   <= 1'b0;
      rd_data  <= 8'h00;
      wr_stb   <= 1'b0;
      wr_addr  <= '0;
      err_cnt  <= 8'h00;
    end else begin
      cs_meta <= cs;
      cs_sync <= cs_meta;
      wr_stb  <= do_write;
      if (do_write) begin
        wr_addr <= hdr_addr;
      end
      if (latch_hdr) begin
        hdr_addr <= cur_a[ADDR_W-1:0];
        hdr_ok   <= cur_ok;
      end
      if (load_rd) begin
        rd_data <= cur_ok ? bank_rdata : SPI_RD_FILL;
      end
      if (bump_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
